// File: rtl/mdu_iterative_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes, FSM encodings, op decode helpers.
// Optional divider datapath is selected with the MDU_DIV_EN macro in the files that use this package.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mdu_iterative_pkg;

    typedef logic [2:0] mdu_op_t;
    typedef logic [1:0] mdu_state_t;

    localparam mdu_op_t MDUOp_MULT  = 3'b001;
    localparam mdu_op_t MDUOp_MULTU = 3'b010;
    localparam mdu_op_t MDUOp_DIV   = 3'b011;
    localparam mdu_op_t MDUOp_DIVU  = 3'b100;
    localparam mdu_op_t MDUOp_MTHI  = 3'b101;
    localparam mdu_op_t MDUOp_MTLO  = 3'b110;

    localparam mdu_state_t ST_IDLE = 2'd0;
    localparam mdu_state_t ST_CALC = 2'd1;
    localparam mdu_state_t ST_FIX  = 2'd2;

    function automatic logic is_mul_op(input mdu_op_t op);
        return (op == MDUOp_MULT) || (op == MDUOp_MULTU);
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == MDUOp_DIV) || (op == MDUOp_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == MDUOp_MULT) || (op == MDUOp_DIV);
    endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Pipeline-to-MDU bundle. Macro MDU_DIV_EN does not change this interface.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface mdu_iterative_if #(
    parameter int WORD_WIDTH = `WORD_WIDTH
);
    import mdu_iterative_pkg::*;

    // Handshake: start is taken only on an edge where busy=0 and flush=0; the
    // issuer holds its request while busy=1. done pulses once in the cycle HI/LO
    // are written, and the new values are visible the following cycle.
    logic                  start;
    mdu_op_t               op;
    logic [WORD_WIDTH-1:0] inA;
    logic [WORD_WIDTH-1:0] inB;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] hi;
    logic [WORD_WIDTH-1:0] lo;
    mdu_state_t            dbg_state;

    modport master (
        output start, op, inA, inB, flush,
        input  busy, done, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, inA, inB, flush,
        output busy, done, hi, lo, dbg_state
    );

endinterface

// File: rtl/mdu_iterative_divider.sv
// mdu_divider: restoring shift-subtract divider on unsigned magnitudes, one quotient bit per step.
// Only instantiated when MDU_DIV_EN is defined.
module mdu_divider #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [WORD_WIDTH-1:0] dividend,
    input  logic [WORD_WIDTH-1:0] divisor,
    output logic [WORD_WIDTH-1:0] quotient,
    output logic [WORD_WIDTH-1:0] remainder,
    output logic                  last
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(W);

    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [W-1:0]  dvsr;
    logic [CW-1:0] cnt;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    // rem always holds fewer than W significant bits before a step, so bit W
    // of diff is a clean borrow flag (also true for a zero divisor).
    always_comb begin
        shifted = {rem, quo[W-1]};
        diff    = shifted - {1'b0, dvsr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo  <= '0;
            rem  <= '0;
            dvsr <= '0;
            cnt  <= '0;
        end else if (load) begin
            quo  <= dividend;
            rem  <= '0;
            dvsr <= divisor;
            cnt  <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (!diff[W]) begin
                rem <= diff[W-1:0];
                quo <= {quo[W-2:0], 1'b1};
            end else begin
                rem <= shifted[W-1:0];
                quo <= {quo[W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign last      = (cnt == CW'(W - 1));

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus single-cycle MTHI/MTLO.
// Define MDU_DIV_EN to include the divider; without it DIV/DIVU complete in one cycle leaving HI/LO untouched.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mdu_iterative
    import mdu_iterative_pkg::*;
#(
    parameter int WORD_WIDTH = `WORD_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    mdu_iterative_if.slave bus
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(W);

    mdu_state_t     state;
    mdu_state_t     state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mcand;
    logic [2*W-1:0] acc;
    logic           is_div;
    logic           neg_res;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    logic           accept;
    logic           op_mul;
    logic           op_div;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod;
    logic           last;

    always_comb begin
        op_mul  = is_mul_op(bus.op);
        op_div  = is_div_op(bus.op);
        a_neg   = is_signed_op(bus.op) & bus.inA[W-1];
        b_neg   = is_signed_op(bus.op) & bus.inB[W-1];
        a_mag   = a_neg ? -bus.inA : bus.inA;
        b_mag   = b_neg ? -bus.inB : bus.inB;
        accept  = (state == ST_IDLE) && bus.start && !bus.flush;
        mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? mcand : {W{1'b0}})};
        prod    = neg_res ? -acc : acc;
    end

`ifdef MDU_DIV_EN
    logic         neg_rem;
    logic         div_last;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;
    logic [W-1:0] quo_fix;
    logic [W-1:0] rem_fix;

    mdu_divider #(.WORD_WIDTH(W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && op_div),
        .step      ((state == ST_CALC) && is_div),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_q),
        .remainder (div_r),
        .last      (div_last)
    );

    // Quotient sign follows the operand signs, remainder follows the dividend.
    always_comb begin
        quo_fix = neg_res ? -div_q : div_q;
        rem_fix = neg_rem ? -div_r : div_r;
        last    = is_div ? div_last : (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst)
            neg_rem <= 1'b0;
        else if (accept && op_div)
            neg_rem <= a_neg;
    end
`else
    assign last = (cnt == CW'(W - 1));
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && op_mul)
                    state_nxt = ST_CALC;
`ifdef MDU_DIV_EN
                else if (accept && op_div)
                    state_nxt = ST_CALC;
`else
                else if (accept && op_div)
                    state_nxt = ST_FIX;
`endif
            end
            ST_CALC: begin
                if (bus.flush)
                    state_nxt = ST_IDLE;
                else if (last)
                    state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_nxt;

            if (accept && (op_mul || op_div)) begin
                mcand   <= a_mag;
                acc     <= {{W{1'b0}}, b_mag};
                cnt     <= '0;
                is_div  <= op_div;
                neg_res <= a_neg ^ b_neg;
            end else if (state == ST_CALC) begin
                cnt <= cnt + 1'b1;
                if (!is_div)
                    acc <= {mul_sum, acc[W-1:1]};
            end

            if (accept && (bus.op == MDUOp_MTHI))
                hi_q <= bus.inA;
            if (accept && (bus.op == MDUOp_MTLO))
                lo_q <= bus.inA;

            // A flush landing on FIX still squashes the architectural write.
            if ((state == ST_FIX) && !bus.flush) begin
                if (!is_div) begin
                    hi_q <= prod[2*W-1:W];
                    lo_q <= prod[W-1:0];
                end
`ifdef MDU_DIV_EN
                else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
`endif
            end
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_FIX);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state;

endmodule
